bram_read_seq: RTL and testbench
================================

# bram_read_seq

Counter-driven BRAM read sequencer: on `start_i` it issues `cnt_val_i` consecutive read addresses from 0, absorbs the BRAM read latency and returns each word on `rdata_o` qualified by `rvalid_o`. It is the read-side companion of the counter-based write accessor in the BRAM accessor path. It drives the same single-port BRAM address/enable port from the read side and exposes the same idle/run/done status style to the controlling FSM.

## Interface
- `AWIDTH`, 8: BRAM address width.
- `DWIDTH`, 32: BRAM data width.
- `CNT_BIT`, 31: width of the read-count request.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start request, sampled only in IDLE.
- `cnt_val_i`  in  CNT_BIT  number of words to read; latched on accepted start.
- `addr_o`  out  AWIDTH  BRAM read address.
- `ce_o`  out  1  BRAM chip enable; high only on issue cycles.
- `we_o`  out  1  BRAM write enable; constant 0.
- `q_i`  in  DWIDTH  BRAM read data.
- `rdata_o`  out  DWIDTH  registered read data.
- `rvalid_o`  out  1  `rdata_o` valid this cycle.
- `read_idle_o`  out  1  FSM in IDLE.
- `read_run_o`  out  1  FSM in RUN or DRAIN.
- `read_done_o`  out  1  one-cycle completion pulse (DONE state).

## Operation
- States are IDLE, RUN, DRAIN and DONE; the FSM is a registered state with combinational status decode.
- Reset values:
  - state = IDLE, so `read_idle_o` = 1.
  - `addr_o`, `ce_o`, `rdata_o`, `rvalid_o`, `read_run_o`, `read_done_o`, the issue counter and the latency pipeline all reset to 0.
- IDLE -> RUN: when `start_i` = 1 and `cnt_val_i` != 0, latch N = `cnt_val_i` and clear the issue counter.
- `start_i` with `cnt_val_i` = 0 is ignored and the FSM stays in IDLE.
- RUN:
  - Every cycle: `ce_o` = 1, `addr_o` = issue count[AWIDTH-1:0], issue count += 1.
  - After the N-th issue, go to DRAIN.
- Address wrap: the issue count is CNT_BIT wide. `addr_o` is its low AWIDTH bits, so it wraps modulo 2^AWIDTH (address 255 -> 0 at the default width). The read count still terminates at exactly N.
- Valid pipeline: a shift register of depth L+1 carries `ce_o`. L is the BRAM latency (see Configuration).
  - When the stage-L bit is 1, `rdata_o` <= `q_i`.
  - `rvalid_o` is the registered output of that stage.
- DRAIN: `ce_o` = 0. Stay until the pipeline is empty and the last `rvalid_o` has been emitted, then go to DONE.
- DONE: `read_done_o` = 1 for exactly one cycle, then IDLE.
- `start_i` is ignored in RUN, DRAIN and DONE; there is no queuing.
- `cnt_val_i` changes after the start is accepted have no effect.
- Reset asserted mid-operation: everything returns to reset values immediately, including the in-flight valids. No `read_done_o` is produced.
- `rdata_o` holds its last value when `rvalid_o` = 0.

## Timing
Cycle numbering: start is sampled at edge 0, so cycle 1 is the first RUN cycle.
- Issue cycles: cycles 1..N carry `ce_o` = 1 with `addr_o` = 0..N-1.
- L = 1: `q_i` is valid in cycle k+1 for an issue in cycle k. `rvalid_o`/`rdata_o` appear in cycle k+2. The total issue-to-`rvalid_o` latency is L+1.
- Last `rvalid_o` is in cycle N+L+1. DONE (`read_done_o` = 1) is cycle N+L+2. IDLE resumes at N+L+3.
- Back-to-back: a `start_i` held high is accepted in the first IDLE cycle after DONE.
- Throughput is one word per cycle. There is no backpressure: the consumer must accept every `rvalid_o` beat.

## Configuration
- Macro `BRAM_OUT_REG_EN`.
  - Defined: the BRAM output register is enabled, so L = 2. The pipeline gains one stage, latency becomes 3, and DONE moves to cycle N+4.
  - Undefined: L = 1, latency 2, DONE at cycle N+3.
- The macro changes no ports or state encoding.

## Test plan
- Reset: hold `reset_n` = 0 -> `read_idle_o` = 1 and every other output 0. Release -> the outputs stay in that state until a start is accepted.
- Basic read: preload mem[i] = 32'hA000_0000+i, start with N = 4 -> `addr_o` = 0,1,2,3 in cycles 1-4. `rvalid_o` in cycles 3-6 with data A0000000..A0000003. `read_done_o` pulse in cycle 7, IDLE in cycle 8.
- Zero and ignored starts: start with N = 0 -> stays IDLE with no `ce_o`. Pulse `start_i` during RUN of an N = 8 read -> exactly 8 reads and one done.
- Wrap: N = 260 with AWIDTH = 8 -> `addr_o` sequence 0..255,0,1,2,3. Exactly 260 `rvalid_o` beats, then done.
- Reset mid-run: assert `reset_n` = 0 after the 3rd issue of an N = 10 read -> outputs cleared immediately and no done pulse. A new start with N = 2 then reads addresses 0 and 1 correctly.
- `BRAM_OUT_REG_EN` build: N = 4 -> `rvalid_o` in cycles 4-7 and done in cycle 8, with data matching the basic-read scenario.

Source files
------------

// File: rtl/bram_read_seq_if.sv
// bram_read_seq_if: groups the control, BRAM-port and read-data signals of
// the BRAM read sequencer. The slave modport is the sequencer itself, and
// the master modport is its surroundings (controlling FSM, BRAM, consumer).
// The parameters must match those of the bram_read_seq instance it is
// attached to.
interface bram_read_seq_if #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int CNT_BIT = 31
);
  logic               start_i;
  logic [CNT_BIT-1:0] cnt_val_i;
  logic [AWIDTH-1:0]  addr_o;
  logic               ce_o;
  logic               we_o;
  logic [DWIDTH-1:0]  q_i;
  logic [DWIDTH-1:0]  rdata_o;
  logic               rvalid_o;
  logic               read_idle_o;
  logic               read_run_o;
  logic               read_done_o;

  modport slave (
    input  start_i, cnt_val_i, q_i,
    output addr_o, ce_o, we_o, rdata_o, rvalid_o,
           read_idle_o, read_run_o, read_done_o
  );

  modport master (
    output start_i, cnt_val_i, q_i,
    input  addr_o, ce_o, we_o, rdata_o, rvalid_o,
           read_idle_o, read_run_o, read_done_o
  );
endinterface

// File: rtl/bram_read_seq.sv
// bram_read_seq: counter-driven BRAM read sequencer. On an accepted start it
// issues N consecutive read addresses from 0, tracks the BRAM read latency
// with a valid shift register and returns each word on rdata_o/rvalid_o.
// Optional build macro BRAM_OUT_REG_EN: the BRAM output register is enabled,
// so the BRAM latency L is 2 cycles instead of 1. Ports and state encoding
// are the same in both builds.
module bram_read_seq #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int CNT_BIT = 31
) (
  input  logic         clk,
  input  logic         reset_n,
  bram_read_seq_if.slave bus
);

`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;     // issues already made in this run
  logic [CNT_BIT-1:0] num_q, num_d;     // requested read count N
  logic [CNT_BIT-1:0] cnt_inc_s;
  logic               issue_s;
  logic [LAT-1:0]     pipe_q, pipe_d;   // ce_o delayed by 1..L cycles
  logic               rvalid_q, rvalid_d;
  logic [DWIDTH-1:0]  rdata_q, rdata_d;

  // Next-state and issue decode; the counter is the read address source.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    issue_s   = 1'b0;
    cnt_inc_s = cnt_q + {{(CNT_BIT-1){1'b0}}, 1'b1};
    case (state_q)
      ST_IDLE: begin
        // A zero-length request is dropped rather than producing a done pulse.
        if (bus.start_i && (bus.cnt_val_i != {CNT_BIT{1'b0}})) begin
          state_d = ST_RUN;
          num_d   = bus.cnt_val_i;
          cnt_d   = {CNT_BIT{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue_s = 1'b1;
        cnt_d   = cnt_inc_s;
        // Termination uses the full-width count, so address wrap is harmless.
        if (cnt_inc_s == num_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Pipeline empty means the final beat is on rvalid_o this cycle.
        if (pipe_q == {LAT{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latency tracking: shift the issue flag and capture q_i when it lands.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = issue_s;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    rvalid_d = pipe_q[LAT-1];
    if (pipe_q[LAT-1]) begin
      rdata_d = bus.q_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, counters and read-data pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_BIT{1'b0}};
      num_q    <= {CNT_BIT{1'b0}};
      pipe_q   <= {LAT{1'b0}};
      rvalid_q <= 1'b0;
      rdata_q  <= {DWIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      pipe_q   <= pipe_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // BRAM port and status outputs decode from registered state only.
  assign bus.ce_o        = issue_s;
  assign bus.addr_o      = issue_s ? cnt_q[AWIDTH-1:0] : {AWIDTH{1'b0}};
  assign bus.we_o        = 1'b0;
  assign bus.rdata_o     = rdata_q;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.read_idle_o = (state_q == ST_IDLE);
  assign bus.read_run_o  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.read_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_bram_read_seq.sv
// tb_bram_read_seq: directed bench for bram_read_seq with a behavioural BRAM.
module tb_bram_read_seq;

`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  bram_read_seq_if bus ();

  bram_read_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: mem[i] = A000_0000 + i, latency LAT.
  logic [31:0] mem [256];
  logic [31:0] q1;
  logic [31:0] q2;
  always @(posedge clk) begin
    if (bus.ce_o) q1 <= mem[bus.addr_o];
    q2 <= q1;
  end
`ifdef BRAM_OUT_REG_EN
  assign bus.q_i = q2;
`else
  assign bus.q_i = q1;
`endif

  typedef struct {
    logic        start;
    logic [30:0] cnt;
    logic        ce;
    logic [7:0]  addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        idle;
    logic        run;
    logic        done;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " idle"},   32'(bus.read_idle_o), 32'd1);
    chk({tag, " ce"},     32'(bus.ce_o),        32'd0);
    chk({tag, " we"},     32'(bus.we_o),        32'd0);
    chk({tag, " addr"},   32'(bus.addr_o),      32'd0);
    chk({tag, " rvalid"}, 32'(bus.rvalid_o),    32'd0);
    chk({tag, " rdata"},  bus.rdata_o,          32'd0);
    chk({tag, " run"},    32'(bus.read_run_o),  32'd0);
    chk({tag, " done"},   32'(bus.read_done_o), 32'd0);
  endtask

  // Starts an N-word read at the current negedge; optionally pulses start
  // (cnt 3) in cycle pulse_at, then checks every issue, beat and the timing.
  task automatic run_read(input int n, input int pulse_at, input string tag);
    int issued, beats, dones, done_cyc, idle_cyc;
    issued = 0; beats = 0; dones = 0; done_cyc = -1; idle_cyc = -1;
    bus.start_i   = 1'b1;
    bus.cnt_val_i = 31'(n);
    @(negedge clk);
    for (int c = 1; c <= n + LAT + 10; c++) begin
      if (c == pulse_at) begin
        bus.start_i   = 1'b1;
        bus.cnt_val_i = 31'd3;
      end else begin
        bus.start_i   = 1'b0;
      end
      #1;
      if (bus.ce_o) begin
        chk({tag, " addr"}, 32'(bus.addr_o), 32'(issued & 255));
        issued++;
      end
      if (bus.rvalid_o) begin
        chk({tag, " rdata"}, bus.rdata_o, 32'hA000_0000 + 32'(beats & 255));
        beats++;
      end
      if (bus.read_done_o) begin
        dones++;
        done_cyc = c;
      end
      if (bus.read_idle_o && dones > 0) begin
        idle_cyc = c;
        break;
      end
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    chk({tag, " issues"},   32'(issued),   32'(n));
    chk({tag, " beats"},    32'(beats),    32'(n));
    chk({tag, " dones"},    32'(dones),    32'd1);
    chk({tag, " done_cyc"}, 32'(done_cyc), 32'(n + LAT + 2));
    chk({tag, " idle_cyc"}, 32'(idle_cyc), 32'(n + LAT + 3));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);

    // Basic N=4 read timeline: cycle 0 samples start, issues in 1..4.
    for (int c = 0; c < 11; c++) begin
      vecs[c].start  = (c == 0);
      vecs[c].cnt    = 31'd4;
      vecs[c].ce     = (c >= 1 && c <= 4);
      vecs[c].addr   = vecs[c].ce ? 8'(c - 1) : 8'd0;
      vecs[c].rvalid = (c >= LAT + 2 && c <= LAT + 5);
      if (c < LAT + 2)       vecs[c].rdata = 32'd0;
      else if (c <= LAT + 5) vecs[c].rdata = 32'hA000_0000 + 32'(c - LAT - 2);
      else                   vecs[c].rdata = 32'hA000_0003;
      vecs[c].run    = (c >= 1 && c <= LAT + 5);
      vecs[c].done   = (c == LAT + 6);
      vecs[c].idle   = (c == 0) || (c >= LAT + 7);
    end

    // Reset held, then released: everything stays quiet until a start.
    reset_n       = 1'b0;
    bus.start_i   = 1'b0;
    bus.cnt_val_i = 31'd0;
    repeat (2) @(negedge clk);
    chk_cleared("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cleared("post_rst");

    // Table-driven basic read.
    for (int c = 0; c < 11; c++) begin
      bus.start_i   = vecs[c].start;
      bus.cnt_val_i = vecs[c].cnt;
      #1;
      chk($sformatf("basic c%0d ce", c),     32'(bus.ce_o),        32'(vecs[c].ce));
      chk($sformatf("basic c%0d addr", c),   32'(bus.addr_o),      32'(vecs[c].addr));
      chk($sformatf("basic c%0d rvalid", c), 32'(bus.rvalid_o),    32'(vecs[c].rvalid));
      chk($sformatf("basic c%0d rdata", c),  bus.rdata_o,          vecs[c].rdata);
      chk($sformatf("basic c%0d idle", c),   32'(bus.read_idle_o), 32'(vecs[c].idle));
      chk($sformatf("basic c%0d run", c),    32'(bus.read_run_o),  32'(vecs[c].run));
      chk($sformatf("basic c%0d done", c),   32'(bus.read_done_o), 32'(vecs[c].done));
      chk($sformatf("basic c%0d we", c),     32'(bus.we_o),        32'd0);
      @(negedge clk);
    end

    // Zero-length start held for several cycles is ignored.
    bus.start_i   = 1'b1;
    bus.cnt_val_i = 31'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("zero idle", 32'(bus.read_idle_o), 32'd1);
      chk("zero ce",   32'(bus.ce_o),        32'd0);
      chk("zero run",  32'(bus.read_run_o),  32'd0);
    end
    bus.start_i = 1'b0;
    @(negedge clk);

    // Start pulse during RUN is ignored.
    run_read(8, 3, "ign");
    @(negedge clk);

    // Address wrap past 255.
    run_read(260, 0, "wrap");
    @(negedge clk);

    // Reset after the third issue of an N=10 read.
    bus.start_i   = 1'b1;
    bus.cnt_val_i = 31'd10;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst rvalid", 32'(bus.rvalid_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_cleared("midrst");
    @(negedge clk);
    chk_cleared("midrst hold");
    reset_n = 1'b1;
    @(negedge clk);
    chk_cleared("midrst rel");
    run_read(2, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
